// File: rtl/arm_mem_pkg.sv
// Shared types, constants and helpers for the wait-state data memory.
// Request fields are sized for the widest supported bus (64 bits); narrower buses use the low bits.
package arm_mem_pkg;

   localparam int MEM_MAX_BUS_WIDTH = 64;
   localparam int MEM_MAX_LANES     = MEM_MAX_BUS_WIDTH / 8;
   localparam int MEM_CNT_WIDTH     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic [MEM_MAX_BUS_WIDTH-1:0] addr;
      logic                         we;
      logic [MEM_MAX_LANES-1:0]     be;
      logic [MEM_MAX_BUS_WIDTH-1:0] wdata;
   } mem_req_t;

   function automatic int mem_idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/arm_byte_lane_ram.sv
// Word-wide RAM built from one byte-wide array per lane, so each lane has its own write strobe.
// The read port is combinational; the caller registers the result.
import arm_mem_pkg::*;

module arm_byte_lane_ram #(
   parameter  int BusWidth    = 32,
   parameter  int DataMemSize = 256,
   localparam int IdxW        = mem_idx_width(DataMemSize)
) (
   input  logic                  i_CLK,
   input  logic                  i_Write_En,
   input  logic [IdxW-1:0]       i_Index,
   input  logic [BusWidth/8-1:0] i_Byte_Enable,
   input  logic [BusWidth-1:0]   i_Write_Data,
   output logic [BusWidth-1:0]   o_Read_Data
);

   genvar gi;
   generate
      for (gi = 0; gi < BusWidth / 8; gi++) begin : g_lane
         logic [7:0] lane_mem [DataMemSize];

         always_ff @(posedge i_CLK) begin
            if (i_Write_En && i_Byte_Enable[gi]) begin
               lane_mem[i_Index] <= i_Write_Data[gi*8 +: 8];
            end
         end

         assign o_Read_Data[gi*8 +: 8] = lane_mem[i_Index];
      end
   endgenerate

endmodule

// File: rtl/arm_wait_state_data_memory.sv
// Word-addressed data RAM with req/ready handshake, programmable read/write wait states and byte strobes.
// Optional ARM_DMEM_ACCESS_CHECK_EN flags misaligned or out-of-range accesses via o_Error.
import arm_mem_pkg::*;

module arm_wait_state_data_memory #(
   parameter int BusWidth     = 32,
   parameter int DataMemSize  = 256,
   parameter int ReadLatency  = 2,
   parameter int WriteLatency = 1
) (
   input  logic                  i_CLK,
   input  logic                  i_RESET,
   input  logic                  i_Req,
   input  logic                  i_Write_Enable,
   input  logic [BusWidth-1:0]   i_Address,
   input  logic [BusWidth/8-1:0] i_Byte_Enable,
   input  logic [BusWidth-1:0]   i_Write_Data,
   output logic                  o_Ready,
   output logic                  o_Done,
   output logic [BusWidth-1:0]   o_Read_Data,
   output logic                  o_Error
);

   localparam int IdxW  = mem_idx_width(DataMemSize);
   localparam int Lanes = BusWidth / 8;

   // Counter holds the remaining WAIT cycles, so a latency of 1 skips WAIT entirely.
   localparam logic [MEM_CNT_WIDTH-1:0] ReadLoad  = MEM_CNT_WIDTH'(ReadLatency - 1);
   localparam logic [MEM_CNT_WIDTH-1:0] WriteLoad = MEM_CNT_WIDTH'(WriteLatency - 1);
   localparam logic [MEM_CNT_WIDTH-1:0] CntOne    = MEM_CNT_WIDTH'(1);

   mem_state_t                 state_reg, state_next;
   logic [MEM_CNT_WIDTH-1:0]   cnt_reg, cnt_next;
   mem_req_t                   req_reg, req_next;
   logic [BusWidth-1:0]        rdata_reg, rdata_next;

   logic                       ready;
   logic                       done;
   logic                       accept;
   logic                       enter_done;
   logic                       cur_legal;
   logic                       ram_we;
   logic [BusWidth-1:0]        cur_addr;
   logic [IdxW-1:0]            cur_idx;
   logic [BusWidth-1:0]        ram_rdata;

   function automatic logic addr_legal(input logic [BusWidth-1:0] a);
`ifdef ARM_DMEM_ACCESS_CHECK_EN
      return (a[1:0] == 2'b00) && ((a >> (IdxW + 2)) == '0);
`else
      return 1'b1;
`endif
   endfunction

   assign accept = i_Req && ready;

   // State register together with the datapath registers it controls.
   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         req_reg   <= '0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         req_reg   <= req_next;
         rdata_reg <= rdata_next;
      end
   end

   always_comb begin : next_state
      state_next = state_reg;
      cnt_next   = cnt_reg;
      req_next   = req_reg;
      if (accept) begin
         req_next.addr  = MEM_MAX_BUS_WIDTH'(i_Address);
         req_next.we    = i_Write_Enable;
         req_next.be    = MEM_MAX_LANES'(i_Byte_Enable);
         req_next.wdata = MEM_MAX_BUS_WIDTH'(i_Write_Data);
         cnt_next       = i_Write_Enable ? WriteLoad : ReadLoad;
         state_next     = (cnt_next == '0) ? DONE : WAIT;
      end else begin
         case (state_reg)
            WAIT: begin
               if (cnt_reg <= CntOne) begin
                  cnt_next   = '0;
                  state_next = DONE;
               end else begin
                  cnt_next = cnt_reg - CntOne;
               end
            end
            DONE:    state_next = IDLE;
            default: state_next = state_reg;
         endcase
      end
   end

   always_comb begin : outputs
      ready = 1'b1;
      done  = 1'b0;
      case (state_reg)
         WAIT:    ready = 1'b0;
         DONE:    done  = 1'b1;
         default: ready = 1'b1;
      endcase
   end

   // The access completing on this edge is the freshly accepted one when latency is 1,
   // otherwise the latched one; req_next covers both cases.
   assign enter_done = (state_next == DONE) && !i_RESET;
   assign cur_addr   = req_next.addr[BusWidth-1:0];
   assign cur_idx    = cur_addr[IdxW+1:2];
   assign cur_legal  = addr_legal(cur_addr);
   assign ram_we     = enter_done && req_next.we && cur_legal;

   always_comb begin : read_capture
      rdata_next = rdata_reg;
      if (enter_done && !req_next.we) begin
         rdata_next = cur_legal ? ram_rdata : '0;
      end
   end

   arm_byte_lane_ram #(
      .BusWidth    (BusWidth),
      .DataMemSize (DataMemSize)
   ) u_ram (
      .i_CLK         (i_CLK),
      .i_Write_En    (ram_we),
      .i_Index       (cur_idx),
      .i_Byte_Enable (req_next.be[Lanes-1:0]),
      .i_Write_Data  (req_next.wdata[BusWidth-1:0]),
      .o_Read_Data   (ram_rdata)
   );

   assign o_Ready     = ready;
   assign o_Done      = done;
   assign o_Read_Data = rdata_reg;

`ifdef ARM_DMEM_ACCESS_CHECK_EN
   assign o_Error = done && !addr_legal(req_reg.addr[BusWidth-1:0]);
`else
   assign o_Error = 1'b0;
`endif

endmodule

// File: tb/tb_arm_wait_state_data_memory.sv
// Testbench for arm_wait_state_data_memory: directed vector table, hand-written corner sequences
// and randomized accesses checked against a word-array reference model.
module tb_arm_wait_state_data_memory;

   logic        clk;
   logic        rst_s    [2];
   logic        req_s    [2];
   logic        we_s     [2];
   logic [31:0] addr_s   [2];
   logic [3:0]  be_s     [2];
   logic [31:0] wd_s     [2];
   logic        ready_s  [2];
   logic        done_s   [2];
   logic [31:0] rdata_s  [2];
   logic        err_s    [2];

   int n_tests = 0;
   int n_fail  = 0;

   // Main instance: default latencies (read 2, write 1).
   arm_wait_state_data_memory #(
      .BusWidth(32), .DataMemSize(256), .ReadLatency(2), .WriteLatency(1)
   ) dut (
      .i_CLK(clk), .i_RESET(rst_s[0]), .i_Req(req_s[0]), .i_Write_Enable(we_s[0]),
      .i_Address(addr_s[0]), .i_Byte_Enable(be_s[0]), .i_Write_Data(wd_s[0]),
      .o_Ready(ready_s[0]), .o_Done(done_s[0]), .o_Read_Data(rdata_s[0]), .o_Error(err_s[0])
   );

   // Second instance: slow writes, single-cycle reads.
   arm_wait_state_data_memory #(
      .BusWidth(32), .DataMemSize(256), .ReadLatency(1), .WriteLatency(3)
   ) dut3 (
      .i_CLK(clk), .i_RESET(rst_s[1]), .i_Req(req_s[1]), .i_Write_Enable(we_s[1]),
      .i_Address(addr_s[1]), .i_Byte_Enable(be_s[1]), .i_Write_Data(wd_s[1]),
      .o_Ready(ready_s[1]), .o_Done(done_s[1]), .o_Read_Data(rdata_s[1]), .o_Error(err_s[1])
   );

   always #5 clk = ~clk;

   // Reference model for the main instance: plain word array plus last read value.
   logic [31:0] mdl_mem [256];
   logic [31:0] mdl_rd;

   function automatic void model_apply(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                       input logic [31:0] wd, output logic [31:0] exp_rd,
                                       output logic exp_err);
      int idx;
      bit bad;
      idx = int'((addr / 4) % 256);
      bad = 1'b0;
`ifdef ARM_DMEM_ACCESS_CHECK_EN
      bad = (addr % 4 != 0) || (addr >= 32'd1024);
`endif
      if (we) begin
         if (!bad)
            for (int b = 0; b < 4; b++)
               if (be[b]) mdl_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
         mdl_rd = bad ? 32'h0 : mdl_mem[idx];
      end
      exp_rd  = mdl_rd;
      exp_err = bad;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where o_Done is seen (or the bound expires).
   task automatic do_access(input int d, input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wd, output int waits, output int lat,
                            output logic rdy_after, output logic [31:0] rd, output logic err);
      waits = 0;
      req_s[d] = 1'b1; we_s[d] = we; addr_s[d] = addr; be_s[d] = be; wd_s[d] = wd;
      while (!ready_s[d] && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      @(negedge clk);
      req_s[d]  = 1'b0;
      rdy_after = ready_s[d];
      lat = 1;
      while (!done_s[d] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rd  = rdata_s[d];
      err = err_s[d];
   endtask

   task automatic model_check(input string tag, input logic we, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wd);
      int waits, lat;
      logic rdy_after, err, exp_err;
      logic [31:0] rd, exp_rd;
      do_access(0, we, addr, be, wd, waits, lat, rdy_after, rd, err);
      model_apply(we, addr, be, wd, exp_rd, exp_err);
      check({tag, " latency"}, 32'(lat), we ? 32'd1 : 32'd2);
      check({tag, " rdata"}, rd, exp_rd);
      check({tag, " error"}, {31'd0, err}, {31'd0, exp_err});
      $display("[TB] %s we=%0d addr=0x%08h be=0x%h wd=0x%08h -> lat=%0d rd=0x%08h err=%0d",
               tag, we, addr, be, wd, lat, rd, err);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int waits, lat, ndone, first;
      logic rdy_after, err, exp_err;
      logic [31:0] rd, exp_rd, wd, addr;

      vecs[0] = '{1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h00000000, 1};
      vecs[1] = '{1'b0, 32'h10, 4'h0, 32'h0,        32'hDEADBEEF, 2};
      vecs[2] = '{1'b1, 32'h10, 4'h1, 32'h000000AA, 32'hDEADBEEF, 1};
      vecs[3] = '{1'b0, 32'h10, 4'h0, 32'h0,        32'hDEADBEAA, 2};
      vecs[4] = '{1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 32'hDEADBEAA, 1};
      vecs[5] = '{1'b0, 32'h10, 4'h0, 32'h0,        32'hDEADBEAA, 2};
      vecs[6] = '{1'b1, 32'h20, 4'hF, 32'h12345678, 32'hDEADBEAA, 1};
      vecs[7] = '{1'b0, 32'h20, 4'h0, 32'h0,        32'h12345678, 2};
      vecs[8] = '{1'b1, 32'h10, 4'h6, 32'h11223344, 32'h12345678, 1};
      vecs[9] = '{1'b0, 32'h10, 4'h0, 32'h0,        32'hDE2233AA, 2};

      clk = 1'b0;
      mdl_rd = 32'h0;
      for (int d = 0; d < 2; d++) begin
         rst_s[d] = 1'b1; req_s[d] = 1'b0; we_s[d] = 1'b0;
         addr_s[d] = '0; be_s[d] = '0; wd_s[d] = '0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset ready[%0d]", d), {31'd0, ready_s[d]}, 32'd1);
         check($sformatf("reset done[%0d]", d),  {31'd0, done_s[d]},  32'd0);
         check($sformatf("reset error[%0d]", d), {31'd0, err_s[d]},   32'd0);
         check($sformatf("reset rdata[%0d]", d), rdata_s[d],          32'd0);
      end
      rst_s[0] = 1'b0; rst_s[1] = 1'b0;
      @(negedge clk);

      // Give the words used by the random phase known contents.
      for (int w = 0; w < 16; w++) begin
         wd = $urandom;
         model_check($sformatf("init w%0d", w), 1'b1, 32'(w * 4), 4'hF, wd);
      end

      // Directed vectors issued back to back: each is presented during the previous DONE cycle.
      for (int i = 0; i < 10; i++) begin
         do_access(0, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wd, waits, lat, rdy_after, rd, err);
         model_apply(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wd, exp_rd, exp_err);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d accept wait", i), 32'(waits), 32'd0);
         check($sformatf("vec%0d ready after accept", i), {31'd0, rdy_after},
               (vecs[i].exp_lat == 1) ? 32'd1 : 32'd0);
         check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d error", i), {31'd0, err}, 32'd0);
         $display("[TB] vec%0d we=%0d addr=0x%08h be=0x%h -> lat=%0d rd=0x%08h",
                  i, vecs[i].we, vecs[i].addr, vecs[i].be, lat, rd);
      end

      // Read stall: fields changed while o_Ready is low must not affect the access.
      @(negedge clk);
      req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h10; be_s[0] = 4'h0; wd_s[0] = 32'h0;
      @(negedge clk);
      check("stall ready low", {31'd0, ready_s[0]}, 32'd0);
      we_s[0] = 1'b1; addr_s[0] = 32'h20; be_s[0] = 4'hF; wd_s[0] = 32'hBAD0BAD0;
      @(negedge clk);
      req_s[0] = 1'b0;
      model_apply(1'b0, 32'h10, 4'h0, 32'h0, exp_rd, exp_err);
      check("stall done", {31'd0, done_s[0]}, 32'd1);
      check("stall rdata", rdata_s[0], exp_rd);
      @(negedge clk);
      check("stall single done", {31'd0, done_s[0]}, 32'd0);
      $display("[TB] read stall rd=0x%08h", rdata_s[0]);
      model_check("stall ignored write", 1'b0, 32'h20, 4'h0, 32'h0);

      // Aliasing / access check corner cases.
      model_check("high addr write", 1'b1, 32'h400, 4'hF, 32'hA5A5A5A5);
      model_check("word0 read", 1'b0, 32'h0, 4'h0, 32'h0);
      model_check("unaligned read", 1'b0, 32'h12, 4'h0, 32'h0);

      // Randomized accesses against the model.
      for (int i = 0; i < 150; i++) begin
         int r;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         addr = 32'($urandom_range(0, 15) * 4);
         r = int'($urandom_range(0, 9));
         if (r == 0) addr = addr + 32'($urandom_range(1, 3) * 1024);
         else if (r == 1) addr = addr + 32'($urandom_range(1, 3));
         model_check($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), addr, 4'($urandom), $urandom);
      end

      // Slow-write instance: stall during a write, then reset in the final WAIT cycle.
      do_access(1, 1'b1, 32'h40, 4'hF, 32'h11111111, waits, lat, rdy_after, rd, err);
      check("w3 latency", 32'(lat), 32'd3);
      check("w3 ready after accept", {31'd0, rdy_after}, 32'd0);
      do_access(1, 1'b0, 32'h40, 4'h0, 32'h0, waits, lat, rdy_after, rd, err);
      check("r1 latency", 32'(lat), 32'd1);
      check("r1 rdata", rd, 32'h11111111);
      $display("[TB] dut3 write/read 0x40 -> rd=0x%08h", rd);

      req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 32'h44; be_s[1] = 4'hF; wd_s[1] = 32'hCAFEF00D;
      @(negedge clk);
      we_s[1] = 1'b0; addr_s[1] = 32'h40; wd_s[1] = 32'h0;
      ndone = 0; first = 0;
      for (int i = 1; i <= 6; i++) begin
         if (done_s[1]) begin
            ndone++;
            if (first == 0) first = i;
            req_s[1] = 1'b0;
         end
         @(negedge clk);
      end
      req_s[1] = 1'b0;
      check("w3 stall done count", 32'(ndone), 32'd1);
      check("w3 stall done cycle", 32'(first), 32'd3);
      do_access(1, 1'b0, 32'h44, 4'h0, 32'h0, waits, lat, rdy_after, rd, err);
      check("w3 stall data", rd, 32'hCAFEF00D);
      do_access(1, 1'b0, 32'h40, 4'h0, 32'h0, waits, lat, rdy_after, rd, err);
      check("w3 stall other addr", rd, 32'h11111111);
      $display("[TB] dut3 write stall done=%0d at cycle %0d", ndone, first);

      req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 32'h40; be_s[1] = 4'hF; wd_s[1] = 32'h22222222;
      @(negedge clk);
      req_s[1] = 1'b0;
      check("rst wait ready", {31'd0, ready_s[1]}, 32'd0);
      @(negedge clk);
      check("rst wait done", {31'd0, done_s[1]}, 32'd0);
      rst_s[1] = 1'b1;
      @(negedge clk);
      rst_s[1] = 1'b0;
      check("rst ready after", {31'd0, ready_s[1]}, 32'd1);
      check("rst no done", {31'd0, done_s[1]}, 32'd0);
      check("rst rdata cleared", rdata_s[1], 32'd0);
      ndone = 0;
      repeat (4) begin
         @(negedge clk);
         if (done_s[1]) ndone++;
      end
      check("rst no late done", 32'(ndone), 32'd0);
      do_access(1, 1'b0, 32'h40, 4'h0, 32'h0, waits, lat, rdy_after, rd, err);
      check("rst write not committed", rd, 32'h11111111);
      $display("[TB] dut3 reset mid-write -> 0x40 reads 0x%08h", rd);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
